// File: rtl/pll_rst_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_rst_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } seq_state_e;

    // Bits needed to count 0..terminal-1; never narrower than one bit.
    function automatic int cnt_width(input int terminal);
        if (terminal <= 2) begin
            return 1;
        end else begin
            return $clog2(terminal);
        end
    endfunction

    function automatic int max2(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level, with synchronous active-low clear.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_r <= {STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives the PLL reset, waits for a stable lock, then releases downstream resets in order;
// retries on lock timeout, re-sequences on lock loss and latches a fault when retries run out.
module pll_reset_sequencer
    import pll_rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int LOCK_STABLE    = 1024,
    parameter int NUM_STAGES     = 3,
    parameter int STAGE_GAP      = 64,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pll_locked,
    output logic                  pll_rst,
    output logic [NUM_STAGES-1:0] rst_out_n,
    output logic                  seq_done,
    output logic [7:0]            lock_lost_cnt,
    output logic                  fault
);

    localparam int CNT_TERM = max2(max2(PLL_RST_CYCLES, LOCK_TIMEOUT), max2(LOCK_STABLE, STAGE_GAP));
    localparam int CW = cnt_width(CNT_TERM);
    localparam int SW = cnt_width(NUM_STAGES);
    localparam int RW = cnt_width(MAX_RETRIES);
    localparam logic [CW-1:0]         CNT_ONE   = CW'(1'b1);
    localparam logic [SW-1:0]         STG_ONE   = SW'(1'b1);
    localparam logic [RW-1:0]         RTY_ONE   = RW'(1'b1);
    localparam logic [NUM_STAGES-1:0] STAGE_ONE = NUM_STAGES'(1'b1);

    seq_state_e            state_r, next_state_s;
    logic [CW-1:0]         cnt_r, cnt_next_s;
    logic [SW-1:0]         stage_r, stage_next_s;
    logic [RW-1:0]         retry_r, retry_next_s;
    logic [NUM_STAGES-1:0] rst_next_s;
    logic [7:0]            lost_next_s;
    logic                  lock_s;

    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_locked),
        .q       (lock_s)
    );

    // Next-state, shared counter, stage/retry bookkeeping and next output values.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        stage_next_s = stage_r;
        retry_next_s = retry_r;
        rst_next_s   = rst_out_n;
        lost_next_s  = lock_lost_cnt;
        case (state_r)
            PLL_RST: begin
                if (cnt_r == CW'(PLL_RST_CYCLES - 1)) begin
                    next_state_s = WAIT_LOCK;
                    cnt_next_s   = {CW{1'b0}};
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    next_state_s = STABLE;
                    cnt_next_s   = {CW{1'b0}};
                end else if (cnt_r == CW'(LOCK_TIMEOUT - 1)) begin
                    cnt_next_s = {CW{1'b0}};
                    if (retry_r == RW'(MAX_RETRIES - 1)) begin
                        next_state_s = FAULT;
                    end else begin
                        retry_next_s = retry_r + RTY_ONE;
                        next_state_s = PLL_RST;
                    end
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    next_state_s = WAIT_LOCK;
                    cnt_next_s   = {CW{1'b0}};
                end else if (cnt_r == CW'(LOCK_STABLE - 1)) begin
                    cnt_next_s   = {CW{1'b0}};
                    stage_next_s = {SW{1'b0}};
                    rst_next_s   = STAGE_ONE;
                    next_state_s = (NUM_STAGES == 1) ? RUN : RELEASE;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            RELEASE, RUN: begin
                if (!lock_s) begin
                    // Lock loss: drop every stage at once and start over with a fresh retry budget.
                    next_state_s = PLL_RST;
                    cnt_next_s   = {CW{1'b0}};
                    retry_next_s = {RW{1'b0}};
                    rst_next_s   = {NUM_STAGES{1'b0}};
                    lost_next_s  = (lock_lost_cnt == 8'hFF) ? lock_lost_cnt : lock_lost_cnt + 8'd1;
                end else if (state_r == RELEASE && cnt_r == CW'(STAGE_GAP - 1)) begin
                    cnt_next_s   = {CW{1'b0}};
                    stage_next_s = stage_r + STG_ONE;
                    rst_next_s   = (rst_out_n << 1'b1) | STAGE_ONE;
                    next_state_s = (stage_r == SW'(NUM_STAGES - 2)) ? RUN : RELEASE;
                end else if (state_r == RELEASE) begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            FAULT: begin
                next_state_s = FAULT;
                rst_next_s   = {NUM_STAGES{1'b0}};
            end
            default: begin
                next_state_s = PLL_RST;
                cnt_next_s   = {CW{1'b0}};
                rst_next_s   = {NUM_STAGES{1'b0}};
            end
        endcase
    end

    // State, counters and registered outputs; outputs reflect the state being entered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r       <= PLL_RST;
            cnt_r         <= {CW{1'b0}};
            stage_r       <= {SW{1'b0}};
            retry_r       <= {RW{1'b0}};
            pll_rst       <= 1'b1;
            rst_out_n     <= {NUM_STAGES{1'b0}};
            seq_done      <= 1'b0;
            lock_lost_cnt <= 8'd0;
            fault         <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            cnt_r         <= cnt_next_s;
            stage_r       <= stage_next_s;
            retry_r       <= retry_next_s;
            pll_rst       <= (next_state_s == PLL_RST) || (next_state_s == FAULT);
            rst_out_n     <= rst_next_s;
            seq_done      <= (next_state_s == RUN);
            lock_lost_cnt <= lost_next_s;
            fault         <= (next_state_s == FAULT);
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Table-driven directed bench for pll_reset_sequencer with reduced timing parameters.
module tb_pll_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       pll_rst;
    logic [2:0] rst_out_n;
    logic       seq_done;
    logic [7:0] lock_lost_cnt;
    logic       fault;

    int checks = 0;
    int passed = 0;
    int inv_viol = 0;
    logic [2:0] prev_ro = 3'b000;

    typedef struct {
        logic       rn;
        logic       lk;
        int         cycles;
        logic       e_pr;
        logic [2:0] e_ro;
        logic       e_sd;
        logic       e_ft;
        logic [7:0] e_lc;
    } vec_t;

    vec_t vecs[$];

    pll_reset_sequencer #(
        .SYNC_STAGES    (2),
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (40),
        .LOCK_STABLE    (8),
        .NUM_STAGES     (3),
        .STAGE_GAP      (5),
        .MAX_RETRIES    (3)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pll_locked    (pll_locked),
        .pll_rst       (pll_rst),
        .rst_out_n     (rst_out_n),
        .seq_done      (seq_done),
        .lock_lost_cnt (lock_lost_cnt),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    // Reset outputs must form a thermometer code that only grows one bit at a time or clears fully.
    always @(negedge clk) begin
        if (!(rst_out_n inside {3'b000, 3'b001, 3'b011, 3'b111})) begin
            inv_viol++;
        end else if (rst_out_n != prev_ro && rst_out_n != 3'b000 &&
                     rst_out_n != ((prev_ro << 1) | 3'b001)) begin
            inv_viol++;
        end
        prev_ro = rst_out_n;
    end

    function automatic void add(input logic rn, input logic lk, input int cy, input logic pr,
                                input logic [2:0] ro, input logic sd, input logic ft,
                                input logic [7:0] lc);
        vec_t v;
        v.rn = rn; v.lk = lk; v.cycles = cy;
        v.e_pr = pr; v.e_ro = ro; v.e_sd = sd; v.e_ft = ft; v.e_lc = lc;
        vecs.push_back(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        pll_locked = 1'b0;

        //   rn    lk    cyc pll_rst rst_out  done  fault lost
        // Nominal bring-up: lock raised 10 cycles after reset release.
        add(1'b0, 1'b0, 3,  1'b1, 3'b000, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b0, 3,  1'b1, 3'b000, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b0, 1,  1'b0, 3'b000, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b0, 6,  1'b0, 3'b000, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b1, 10, 1'b0, 3'b000, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b1, 1,  1'b0, 3'b001, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b1, 4,  1'b0, 3'b001, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b1, 1,  1'b0, 3'b011, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b1, 4,  1'b0, 3'b011, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b1, 1,  1'b0, 3'b111, 1'b1, 1'b0, 8'd0);
        add(1'b1, 1'b1, 5,  1'b0, 3'b111, 1'b1, 1'b0, 8'd0);
        // Lock loss in RUN for 3 cycles, then full re-sequence.
        add(1'b1, 1'b0, 2,  1'b0, 3'b111, 1'b1, 1'b0, 8'd0);
        add(1'b1, 1'b0, 1,  1'b1, 3'b000, 1'b0, 1'b0, 8'd1);
        add(1'b1, 1'b1, 3,  1'b1, 3'b000, 1'b0, 1'b0, 8'd1);
        add(1'b1, 1'b1, 1,  1'b0, 3'b000, 1'b0, 1'b0, 8'd1);
        add(1'b1, 1'b1, 8,  1'b0, 3'b000, 1'b0, 1'b0, 8'd1);
        add(1'b1, 1'b1, 1,  1'b0, 3'b001, 1'b0, 1'b0, 8'd1);
        add(1'b1, 1'b1, 10, 1'b0, 3'b111, 1'b1, 1'b0, 8'd1);
        // Second loss from RUN, re-sequence to bit 0 only, then lose lock in RELEASE.
        add(1'b1, 1'b0, 3,  1'b1, 3'b000, 1'b0, 1'b0, 8'd2);
        add(1'b1, 1'b1, 13, 1'b0, 3'b001, 1'b0, 1'b0, 8'd2);
        add(1'b1, 1'b0, 2,  1'b0, 3'b001, 1'b0, 1'b0, 8'd2);
        add(1'b1, 1'b0, 1,  1'b1, 3'b000, 1'b0, 1'b0, 8'd3);
        // Re-sequence to bit 0, then a one-cycle reset pulse mid-RELEASE.
        add(1'b1, 1'b1, 13, 1'b0, 3'b001, 1'b0, 1'b0, 8'd3);
        add(1'b0, 1'b1, 1,  1'b1, 3'b000, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b1, 3,  1'b1, 3'b000, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b1, 1,  1'b0, 3'b000, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b1, 8,  1'b0, 3'b000, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b1, 1,  1'b0, 3'b001, 1'b0, 1'b0, 8'd0);
        // Timeout/retry with lock never arriving: pulses every 44 cycles, then FAULT.
        add(1'b0, 1'b0, 2,  1'b1, 3'b000, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b0, 3,  1'b1, 3'b000, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b0, 1,  1'b0, 3'b000, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b0, 39, 1'b0, 3'b000, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b0, 1,  1'b1, 3'b000, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b0, 3,  1'b1, 3'b000, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b0, 1,  1'b0, 3'b000, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b0, 39, 1'b0, 3'b000, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b0, 1,  1'b1, 3'b000, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b0, 4,  1'b0, 3'b000, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b0, 39, 1'b0, 3'b000, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b0, 1,  1'b1, 3'b000, 1'b0, 1'b1, 8'd0);
        add(1'b1, 1'b1, 20, 1'b1, 3'b000, 1'b0, 1'b1, 8'd0);
        // Glitchy lock: 5 high, 1 low, then high; release waits for 8 clean synced cycles.
        add(1'b0, 1'b0, 2,  1'b1, 3'b000, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b0, 4,  1'b0, 3'b000, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b1, 5,  1'b0, 3'b000, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b0, 1,  1'b0, 3'b000, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b1, 10, 1'b0, 3'b000, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b1, 1,  1'b0, 3'b001, 1'b0, 1'b0, 8'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset_n    = vecs[i].rn;
            pll_locked = vecs[i].lk;
            repeat (vecs[i].cycles) tick();
            check("pll_rst",       i, 32'(pll_rst),       32'(vecs[i].e_pr));
            check("rst_out_n",     i, 32'(rst_out_n),     32'(vecs[i].e_ro));
            check("seq_done",      i, 32'(seq_done),      32'(vecs[i].e_sd));
            check("fault",         i, 32'(fault),         32'(vecs[i].e_ft));
            check("lock_lost_cnt", i, 32'(lock_lost_cnt), 32'(vecs[i].e_lc));
        end

        // From bit 0 release, seq_done must follow after exactly two stage gaps.
        begin
            int n = 0;
            while (!seq_done && n < 30) begin
                tick();
                n++;
            end
            check("done_latency", vecs.size(), 32'(n), 32'd10);
            check("final_rst_out_n", vecs.size(), 32'(rst_out_n), 32'd7);
        end

        check("order_invariant_violations", vecs.size(), 32'(inv_viol), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
